// File: rtl/fs_serial_2ip.sv
// Digit-serial subtractor: captures a/b, computes a - b one DIGIT-wide slice
// per cycle with a rippling borrow, and presents the result under a valid/ready handshake.
module fs_serial_2ip #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             borrow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One digit of subtraction; bit DIGIT of the result is the borrow-out.
    function automatic logic [DIGIT:0] digit_sub(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             bin
    );
        logic [DIGIT:0] r;
        r = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             borrow_q, borrow_d;
    logic             chain_q, chain_d;
    logic [KW-1:0]    k_q, k_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [DIGIT:0]   digit_res_d;
    int               lo_d;

    // Next-state, datapath and registered-handshake decode.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        borrow_d    = borrow_q;
        chain_d     = chain_q;
        k_d         = k_q;
        digit_res_d = '0;
        lo_d        = int'(k_q) * DIGIT;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    k_d     = '0;
                    chain_d = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                digit_res_d = digit_sub(a_q[lo_d +: DIGIT], b_q[lo_d +: DIGIT], chain_q);
                out_d[lo_d +: DIGIT] = digit_res_d[DIGIT-1:0];
                chain_d = digit_res_d[DIGIT];
                if (k_q == LAST_K) begin
                    borrow_d = digit_res_d[DIGIT];
                    k_d      = '0;
                    state_d  = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the upcoming state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            borrow_q    <= 1'b0;
            chain_q     <= 1'b0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            borrow_q    <= borrow_d;
            chain_q     <= chain_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_fs_serial_2ip.sv
// Directed self-checking bench for fs_serial_2ip (defaults WIDTH=16, DIGIT=4).
module tb_fs_serial_2ip;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        borrow;

    int errors;
    int checks;

    fs_serial_2ip #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .borrow    (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents one operand pair for one edge.
    task automatic do_accept(input logic [15:0] av, input logic [15:0] bv, output bit ok);
        ok = 1'b0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; lat = -1 on timeout.
    task automatic wait_done(output int lat, output logic [15:0] o, output logic bo);
        lat = -1;
        o = 16'h0000;
        bo = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                o = out;
                bo = borrow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", out); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b want 0", borrow); end
    endtask

    task automatic test_basic();
        bit ok; int lat; logic [15:0] o; logic bo;
        out_ready = 1'b1;
        do_accept(16'h1234, 16'h0034, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_accept: got no accept want accept"); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_run_in_ready: got %b want 0", in_ready); end
        wait_done(lat, o, bo);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
        checks++; if (o !== 16'h1200) begin errors++; $display("FAIL basic_out: got %h want 1200", o); end
        checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b want 0", bo); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        checks++; if (out !== 16'h1200) begin errors++; $display("FAIL basic_idle_hold: got %h want 1200", out); end
    endtask

    task automatic test_wrap();
        bit ok; int lat; logic [15:0] o; logic bo;
        out_ready = 1'b1;
        do_accept(16'h0000, 16'h0001, ok);
        wait_done(lat, o, bo);
        checks++; if (o !== 16'hFFFF || bo !== 1'b1) begin errors++; $display("FAIL wrap_under: got %h/%b want FFFF/1", o, bo); end
        do_accept(16'h8000, 16'h8000, ok);
        wait_done(lat, o, bo);
        checks++; if (o !== 16'h0000 || bo !== 1'b0) begin errors++; $display("FAIL wrap_equal: got %h/%b want 0000/0", o, bo); end
        do_accept(16'h0100, 16'h0001, ok);
        wait_done(lat, o, bo);
        checks++; if (o !== 16'h00FF || bo !== 1'b0) begin errors++; $display("FAIL wrap_ripple: got %h/%b want 00FF/0", o, bo); end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok; int lat; logic [15:0] o; logic bo; int bad;
        out_ready = 1'b0;
        do_accept(16'h0F00, 16'h00F1, ok);
        wait_done(lat, o, bo);
        checks++; if (o !== 16'h0E0F || bo !== 1'b0) begin errors++; $display("FAIL bp_result: got %h/%b want 0E0F/0", o, bo); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out !== 16'h0E0F || borrow !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        bit ok; int lat; logic [15:0] o; logic bo; int seen;
        out_ready = 1'b1;
        do_accept(16'hFFFF, 16'h0001, ok);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
        checks++; if (out !== 16'h0000 || borrow !== 1'b0) begin errors++; $display("FAIL rstmid_out: got %h/%b want 0000/0", out, borrow); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", seen); end
        do_accept(16'h0005, 16'h0007, ok);
        wait_done(lat, o, bo);
        checks++; if (o !== 16'hFFFE || bo !== 1'b1) begin errors++; $display("FAIL rstmid_next: got %h/%b want FFFE/1", o, bo); end
        tick();
    endtask

    task automatic test_ignore_inputs();
        bit ok; int bad; logic [15:0] o;
        out_ready = 1'b0;
        do_accept(16'h1357, 16'h0246, ok);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = 16'hAAAA ^ 16'(i);
            b = 16'h5555 + 16'(i);
            tick();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ign_done: got valid=%b want 1", out_valid); end
        o = out;
        checks++; if (o !== 16'h1111 || borrow !== 1'b0) begin errors++; $display("FAIL ign_result: got %h/%b want 1111/0", o, borrow); end
        for (int i = 0; i < 3; i++) begin
            a = 16'hAAAA + 16'(i);
            tick();
            if (in_ready !== 1'b0 || out !== 16'h1111 || out_valid !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ign_done_hold: got %0d bad cycles want 0", bad); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ign_back_idle: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'h4000;
        b = 16'h0001;
        for (int cyc = 0; cyc < 60 && acc.size() < 3; cyc++) begin
            if (in_valid && in_ready) acc.push_back(cyc);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (acc.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d accepts want 3", acc.size());
        end else if (acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) begin
            errors++; $display("FAIL b2b_period: got %0d,%0d want 6,6", acc[1] - acc[0], acc[2] - acc[1]);
        end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (out !== 16'h3FFF || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_last: got %h ready=%b want 3FFF/1", out, in_ready); end
    endtask

    task automatic test_random_stream();
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        logic [15:0] ea, eb, ao;
        logic ab;
        bit hi, ho;
        int sent, done;
        sent = 0;
        done = 0;
        for (int cyc = 0; cyc < 40000 && (sent < 1000 || qa.size() > 0); cyc++) begin
            in_valid = (sent < 1000) && ($urandom_range(3, 0) != 0);
            a = 16'($urandom);
            b = ($urandom_range(7, 0) == 0) ? a : 16'($urandom);
            out_ready = ($urandom_range(1, 0) == 1);
            hi = in_valid && in_ready;
            ho = out_valid && out_ready;
            ao = out;
            ab = borrow;
            if (hi) begin
                qa.push_back(a);
                qb.push_back(b);
                sent++;
            end
            if (ho) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++; $display("FAIL rand_extra: got result %h with nothing pending", ao);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    if (ao !== 16'(ea - eb) || ab !== (ea < eb)) begin
                        errors++;
                        $display("FAIL rand_result: a=%h b=%h got %h/%b want %h/%b", ea, eb, ao, ab, 16'(ea - eb), (ea < eb));
                    end
                end
                done++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (sent != 1000 || done != 1000) begin errors++; $display("FAIL rand_count: got sent=%0d done=%0d want 1000/1000", sent, done); end
        tick();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 16'h0000;
        b = 16'h0000;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_ignore_inputs();
        test_back_to_back();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
